// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle-simulator turn sequencer.
package pbs_pkg;

  typedef enum logic [3:0] {
    WAIT_P,
    P_SEL,
    P_APPLY,
    P_CHK,
    GAP,
    SPIN,
    AI_SEL,
    AI_APPLY,
    AI_CHK,
    OVER
  } state_t;

  localparam logic [3:0] HP_MAX = 4'hF;

  localparam logic TRAINER_PLAYER = 1'b0;
  localparam logic TRAINER_AI     = 1'b1;
  localparam logic TGT_PLAYER     = 1'b0;
  localparam logic TGT_AI         = 1'b1;

  typedef struct packed {
    logic actr;
    logic target;
    logic app_dmg;
    logic stop;
  } ctl_t;

  function automatic ctl_t state_ctl(input state_t s);
    ctl_t c;
    c = '{actr: TRAINER_PLAYER, target: TGT_AI, app_dmg: 1'b0, stop: 1'b0};
    case (s)
      P_APPLY:  c.app_dmg = 1'b1;
      SPIN:     c = '{actr: TRAINER_AI, target: TGT_PLAYER, app_dmg: 1'b0, stop: 1'b0};
      AI_SEL:   c = '{actr: TRAINER_AI, target: TGT_PLAYER, app_dmg: 1'b0, stop: 1'b1};
      AI_APPLY: c = '{actr: TRAINER_AI, target: TGT_PLAYER, app_dmg: 1'b1, stop: 1'b1};
      OVER:     c.stop = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pbs_btn_sync.sv
// Two-flop synchronizer for the raw confirm button plus a registered rising-edge pulse.
module pbs_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], din};
      pulse <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/pbs_ctrl.sv
// Turn sequencer: player hit, display gap, AI RNG spin, AI hit, then winner detection.
//
// state    | meaning
// WAIT_P   | idle, waiting for a synchronized confirm press
// P_SEL    | datapath loads the player move
// P_APPLY  | player damage strobe into AI_hp
// P_CHK    | test AI_hp for a player win
// GAP      | hold so the new AI HP is visible
// SPIN     | AI RNGs free-run
// AI_SEL   | RNGs frozen, datapath loads the AI move
// AI_APPLY | AI damage strobe into p_hp
// AI_CHK   | test p_hp for an AI win, count the turn
// OVER     | game finished, held until reset
module pbs_ctrl
  import pbs_pkg::*;
#(
  parameter int SPIN_CYC = 16,
  parameter int GAP_CYC  = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_go,
  input  logic [3:0] p_hp,
  input  logic [3:0] AI_hp,
  output logic       actr,
  output logic       target,
  output logic       app_dmg,
  output logic       stop,
  output logic       busy,
  output logic       game_over,
  output logic       p_won,
  output logic [7:0] turn_cnt
);

  // GAP lasts GAP_CYC cycles (min 1); SPIN counts down from SPIN_CYC to 0 inclusive.
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SPIN_LOAD = CNT_W'(SPIN_CYC);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             go_pulse;

  pbs_btn_sync u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (p_go),
    .pulse (go_pulse)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      WAIT_P: begin
        if (p_hp == 4'd0 || AI_hp == 4'd0) state_nx = OVER;
        else if (go_pulse)                 state_nx = P_SEL;
      end
      P_SEL:   state_nx = P_APPLY;
      P_APPLY: state_nx = P_CHK;
      P_CHK: begin
        if (AI_hp == 4'd0) begin
          state_nx = OVER;
        end else begin
          cnt_nx   = GAP_LOAD;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          cnt_nx   = SPIN_LOAD;
          state_nx = SPIN;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      SPIN: begin
        if (cnt == '0) state_nx = AI_SEL;
        else           cnt_nx   = cnt - 1'b1;
      end
      AI_SEL:   state_nx = AI_APPLY;
      AI_APPLY: state_nx = AI_CHK;
      AI_CHK:   state_nx = (p_hp == 4'd0) ? OVER : WAIT_P;
      OVER:     state_nx = OVER;
      default:  state_nx = WAIT_P;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= WAIT_P;
      cnt       <= '0;
      actr      <= TRAINER_PLAYER;
      target    <= TGT_AI;
      app_dmg   <= 1'b0;
      stop      <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      p_won     <= 1'b0;
      turn_cnt  <= '0;
    end else begin
      state                         <= state_nx;
      cnt                           <= cnt_nx;
      {actr, target, app_dmg, stop} <= state_ctl(state_nx);
      busy                          <= (state_nx != WAIT_P);
      game_over                     <= (state_nx == OVER);
      if (state == P_CHK && state_nx == OVER) p_won <= 1'b1;
      if (state == AI_CHK && state_nx == WAIT_P && turn_cnt != 8'hFF)
        turn_cnt <= turn_cnt + 8'd1;
    end
  end

endmodule

// File: doc/pbs_ctrl.md
Name: pbs_ctrl

Overview:
Turn-sequencing controller for the battle simulator; drives the battle datapath's control inputs: actr (move source), target, app_dmg, stop (RNG freeze).
- Waits for a player confirm press, applies the player's move to the AI, then lets the AI RNGs run and applies the AI's move to the player.
- Declares the winner when either HP reaches 0.
- Sits between the button/switch front end and the datapath; reads back p_hp/AI_hp.

Parameters:
SPIN_CYC, 16, cycles AI RNGs free-run (stop=0) before the AI move is latched; must be >=1.
GAP_CYC, 8, idle cycles between the player hit and the AI spin, giving the display time to show the new HP; 0 allowed.
CNT_W, 8, width of the internal spin/gap counter; must hold max(SPIN_CYC, GAP_CYC).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
p_go  in  1  raw player confirm button, asynchronous level
p_hp  in  4  player HP from datapath
AI_hp  in  4  AI HP from datapath
actr  out  1  0 = player move selected, 1 = AI RNG move selected
target  out  1  0 = damage player, 1 = damage AI
app_dmg  out  1  one-cycle damage-apply strobe
stop  out  1  1 freezes AI/accuracy RNGs
busy  out  1  high whenever state != WAIT_P
game_over  out  1  sticky until reset
p_won  out  1  valid when game_over; 1 = player won
turn_cnt  out  8  completed full turns, saturates at 255

Behaviour:
- Reset (rst=0 at a clk edge): state=WAIT_P; actr=0, target=1, app_dmg=0, stop=0, busy=0, game_over=0, p_won=0, turn_cnt=0, counter=0; synchronizer flops cleared.
- Reset mid-turn aborts immediately, with no further app_dmg.
- p_go passes through a 2-flop synchronizer plus rising-edge detect, yielding go_pulse 3 cycles after the raw rise.
- go_pulse is honoured only in WAIT_P; it is discarded in every other state.
- All outputs are registered Moore outputs of state.
- States and outputs: actr / target / app_dmg / stop.
  - WAIT_P (0/1/0/0):
    - If p_hp==0 or AI_hp==0, go to OVER (defensive check). This has priority over go_pulse.
    - Else go_pulse -> P_SEL.
  - P_SEL (0/1/0/0): one cycle; the datapath loads the player move register -> P_APPLY.
  - P_APPLY (0/1/1/0): exactly one cycle; AI_hp updates at the end of it -> P_CHK.
  - P_CHK (0/1/0/0):
    - AI_hp==0 -> OVER with p_won=1.
    - Else clear counter -> GAP.
  - GAP (0/1/0/0): count GAP_CYC cycles, then clear counter -> SPIN. GAP_CYC=0 means one pass-through cycle.
  - SPIN (1/0/0/0): RNGs run; count SPIN_CYC cycles -> AI_SEL.
  - AI_SEL (1/0/0/1): RNGs frozen; the datapath loads the AI move -> AI_APPLY.
  - AI_APPLY (1/0/1/1): one cycle; p_hp updates -> AI_CHK.
  - AI_CHK (0/1/0/0):
    - p_hp==0 -> OVER with p_won=0.
    - Else turn_cnt+1 (saturating) -> WAIT_P.
  - OVER (0/1/0/1): game_over=1; stays until reset; go_pulse ignored.
- Latency from go_pulse visible in WAIT_P:
  - app_dmg(target=1) asserts 2 cycles later.
  - AI app_dmg asserts 1+1+1+(GAP_CYC or 1)+SPIN_CYC+1 cycles after the player app_dmg.
- app_dmg is never high in two consecutive cycles and never high with stop=0 when actr=1.
- Simultaneous zero HP: in P_CHK only AI_hp is tested, so the player wins first.
- HP values are treated as unsigned 4-bit; only ==0 is tested.

Decomposition:
- Shared package pbs_pkg:
  - state enum (WAIT_P, P_SEL, P_APPLY, P_CHK, GAP, SPIN, AI_SEL, AI_APPLY, AI_CHK, OVER)
  - HP_MAX=4'hF
  - TRAINER_PLAYER=1'b0, TRAINER_AI=1'b1
  - TGT_PLAYER=1'b0, TGT_AI=1'b1
- One sub-module: pbs_btn_sync (2-flop synchronizer + rising-edge pulse, synchronous active-low reset).

Test Plan:
1. Reset with p_hp=AI_hp=15, no press -> outputs stay 0/1/0/0, busy=0, turn_cnt=0 for 100 cycles.
2. Press p_go, model dmg=3 -> one app_dmg with target=1, AI_hp 15->12. With GAP_CYC=8, SPIN_CYC=16 the second app_dmg (target=0, actr=1, stop=1) comes exactly 28 cycles later; turn_cnt=1; busy drops.
3. Hold p_go high throughout, then press repeatedly during busy -> exactly one turn per rising edge seen in WAIT_P; extra presses produce no app_dmg.
4. AI_hp=2, dmg=3 -> AI_hp=0 in P_CHK -> game_over=1, p_won=1, no AI app_dmg, stop=1 held; later presses ignored.
5. p_hp=1, AI move dmg=2 -> game_over=1, p_won=0, turn_cnt unchanged.
6. Assert rst=0 during SPIN -> next cycle WAIT_P, all outputs at reset values, no app_dmg; turn_cnt saturates at 255 after 300 forced turns.
